// File: rtl/bitstream_loader.sv
// bitstream_loader: streams configuration bytes LSB-first into the fabric
// programming chain (prog_en/prog_in) and reports a CRC-16-CCITT signature.
// Ports: clk, rst (sync, active-low), start, in_data/in_valid/in_ready
//   byte stream, prog_en/prog_in/prog_out chain pins, busy, done, error,
//   signature[15:0].
// Build option: define LOADER_READBACK_EN to add the chain readback pass
//   and signature compare; otherwise error is tied low and prog_out unused.
module bitstream_loader #(
    parameter int CHAIN_LEN = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        prog_en,
    output logic        prog_in,
    input  logic        prog_out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] signature
);

    localparam int CW     = $clog2(CHAIN_LEN + 1);
    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int BW     = $clog2(NBYTES + 1);

    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN);
    localparam logic [BW-1:0] MAX_BYTE = BW'(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READBACK,
        S_DONE
    } state_t;

    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic        b
    );
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_vld_q, hold_vld_d;
    logic [7:0]      sh_q, sh_d;
    logic [3:0]      sh_cnt_q, sh_cnt_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [15:0]     crc_q, crc_d;
    logic            prog_en_q, prog_en_d;
    logic            prog_in_q, prog_in_d;
    logic            accept;
    logic            emit;
    logic            emit_bit;

`ifdef LOADER_READBACK_EN
    localparam logic [CW-1:0] LAST_RB = CW'(CHAIN_LEN - 1);
    logic [15:0]     rb_crc_q, rb_crc_d;
    logic [15:0]     rb_next;
    logic            err_q, err_d;
`endif

    assign in_ready = (state_q == S_LOAD) && !hold_vld_q
                      && (byte_cnt_q < MAX_BYTE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        sh_d       = sh_q;
        sh_cnt_d   = sh_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        prog_en_d  = 1'b0;
        prog_in_d  = 1'b0;
        emit       = 1'b0;
        emit_bit   = 1'b0;
`ifdef LOADER_READBACK_EN
        rb_crc_d   = rb_crc_q;
        rb_next    = crc_step(rb_crc_q, prog_out);
        err_d      = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    hold_vld_d = 1'b0;
                    sh_cnt_d   = 4'd0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    crc_d      = 16'hFFFF;
`ifdef LOADER_READBACK_EN
                    err_d      = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (bit_cnt_q == LAST_BIT) begin
                    // Leftover bits of the final byte are dropped here.
                    hold_vld_d = 1'b0;
                    sh_cnt_d   = 4'd0;
`ifdef LOADER_READBACK_EN
                    state_d    = S_READBACK;
                    bit_cnt_d  = '0;
                    rb_crc_d   = 16'hFFFF;
                    prog_en_d  = 1'b1;
`else
                    state_d    = S_DONE;
`endif
                end else begin
                    if (sh_cnt_q != 4'd0) begin
                        emit     = 1'b1;
                        emit_bit = sh_q[0];
                        sh_d     = {1'b0, sh_q[7:1]};
                        sh_cnt_d = sh_cnt_q - 4'd1;
                    end else if (hold_vld_q) begin
                        // Empty shifter takes the held byte and emits its
                        // bit 0 in the same cycle, so there is no bubble.
                        emit       = 1'b1;
                        emit_bit   = hold_q[0];
                        sh_d       = {1'b0, hold_q[7:1]};
                        sh_cnt_d   = 4'd7;
                        hold_vld_d = 1'b0;
                    end
                    if (emit) begin
                        prog_en_d = 1'b1;
                        prog_in_d = emit_bit;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        crc_d     = crc_step(crc_q, emit_bit);
                    end
                    if (accept) begin
                        hold_d     = in_data;
                        hold_vld_d = 1'b1;
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end
`ifdef LOADER_READBACK_EN
            S_READBACK: begin
                rb_crc_d  = rb_next;
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (bit_cnt_q == LAST_RB) begin
                    state_d = S_DONE;
                    err_d   = (rb_next != crc_q);
                end else begin
                    prog_en_d = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            sh_q       <= '0;
            sh_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            crc_q      <= '0;
            prog_en_q  <= 1'b0;
            prog_in_q  <= 1'b0;
`ifdef LOADER_READBACK_EN
            rb_crc_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            sh_q       <= sh_d;
            sh_cnt_q   <= sh_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            prog_en_q  <= prog_en_d;
            prog_in_q  <= prog_in_d;
`ifdef LOADER_READBACK_EN
            rb_crc_q   <= rb_crc_d;
            err_q      <= err_d;
`endif
        end
    end

    assign prog_en   = prog_en_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_READBACK);
    assign done      = (state_q == S_DONE);
    assign signature = crc_q;

`ifdef LOADER_READBACK_EN
    // Recirculate the chain so its contents survive the readback pass.
    assign prog_in = (state_q == S_READBACK) ? prog_out : prog_in_q;
    assign error   = err_q;
`else
    logic unused_prog_out;
    assign unused_prog_out = prog_out;
    assign prog_in = prog_in_q;
    assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_bitstream_loader.sv
// tb_bitstream_loader: drives bitstream_loader (CHAIN_LEN=20) against a
// 20-bit chain model and a behavioural reference of bits, CRC and chain.
module tb_bitstream_loader;

    localparam int N = 20;
`ifdef LOADER_READBACK_EN
    localparam int EXP_EN = 2 * N;
`else
    localparam int EXP_EN = N;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        prog_en;
    logic        prog_in;
    logic        prog_out;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] signature;

    int n_err = 0;
    int n_chk = 0;

    logic [N-1:0] chain = '0;
    int           nshift = 0;
    bit           flip_arm = 1'b0;
    int           flip_at = 0;

    logic [7:0] src [3];
    int         hold_off [3];

    int   en;
    int   gap;
    int   taken;
    bit   saw_done;
    logic err_at_done;
    logic err1;
    logic busy1;
    logic q_bits [$];

    bitstream_loader #(.CHAIN_LEN(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prog_en   (prog_en),
        .prog_in   (prog_in),
        .prog_out  (prog_out),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .signature (signature)
    );

    always #5 clk = ~clk;

    // Fabric chain: shifts in at bit 0, oldest bit leaves at the top.
    assign prog_out = chain[N-1];
    always @(posedge clk) begin
        if (prog_en) begin
            chain  <= {chain[N-2:0], prog_in}
                      ^ ((flip_arm && (nshift + 1 == flip_at))
                         ? 20'h00080 : 20'h00000);
            nshift <= nshift + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_bits();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[k] = src[k/8][k%8];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_chain(input logic [N-1:0] b);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[N-1-k] = b[k];
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_crc(input logic [N-1:0] b);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < N; k++) begin
            if (c[15] ^ b[k]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    task automatic run_load(input bit busy_pulse, input int abort_at);
        int idx;
        int wait_left;
        int pend;
        bit fire;
        idx = 0;
        wait_left = 0;
        pend = 0;
        fire = 1'b0;
        en = 0;
        gap = 0;
        saw_done = 1'b0;
        err_at_done = 1'bx;
        err1 = 1'bx;
        busy1 = 1'bx;
        q_bits.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (busy_pulse && cyc == 8);
            if (cyc == 1) begin
                err1  = error;
                busy1 = busy;
            end
            if (fire) begin
                idx++;
                if (idx < 3) wait_left = hold_off[idx];
            end
            if (prog_en) begin
                if (en > 0) gap += pend;
                pend = 0;
                en++;
                q_bits.push_back(prog_in);
            end else if (en > 0) begin
                pend++;
            end
            if (abort_at > 0 && en == abort_at) begin
                rst = 1'b0;
                break;
            end
            if (done) begin
                saw_done = 1'b1;
                err_at_done = error;
                break;
            end
            if (idx >= 3) begin
                in_valid = 1'b1;
                in_data  = 8'hEE;
            end else if (wait_left > 0) begin
                in_valid = 1'b0;
                wait_left--;
            end else begin
                in_valid = 1'b1;
                in_data  = src[idx];
            end
            fire = in_valid && in_ready;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        taken    = idx;
    endtask

    task automatic verify(input int exp_gap, input bit flipped);
        logic [N-1:0] eb;
        logic [N-1:0] gb;
        eb = exp_bits();
        for (int k = 0; k < N; k++) begin
            gb[k] = (q_bits.size() > k) ? q_bits[k] : 1'bx;
        end
        check("done_seen", 32'(saw_done), 32'd1);
        check("start_busy", 32'(busy1), 32'd1);
        check("start_err_clr", 32'(err1), 32'd0);
        check("en_cycles", en, EXP_EN);
        check("load_bits", 32'(gb), 32'(eb));
        if (exp_gap >= 0) check("gap", gap, exp_gap);
        check("bytes_taken", taken, 3);
        check("signature", 32'(signature), 32'(ref_crc(eb)));
        check("busy_at_done", 32'(busy), 32'd0);
        check("err_at_done", 32'(err_at_done), 32'(flipped));
        if (!flipped) begin
            check("chain", 32'(chain), 32'(exp_chain(eb)));
        end
`ifdef LOADER_READBACK_EN
        if (!flipped) begin
            for (int k = 0; k < N; k++) begin
                gb[k] = (q_bits.size() > N + k) ? q_bits[N+k] : 1'bx;
            end
            check("rb_bits", 32'(gb), 32'(eb));
        end
`endif
    endtask

    task automatic set_src(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input int h1,
                           input int h2);
        src[0] = a;
        src[1] = b;
        src[2] = c;
        hold_off[0] = 0;
        hold_off[1] = h1;
        hold_off[2] = h2;
    endtask

    initial begin
        int x_en;
        int x_done;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_prog_en", 32'(prog_en), 32'd0);
        check("rst_prog_in", 32'(prog_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Continuous load.
        set_src(8'hA5, 8'h3C, 8'h0F, 0, 0);
        run_load(1'b0, 0);
        verify(0, 1'b0);

        // Underrun: second byte held back long enough for a 5-cycle bubble.
        set_src(8'hA5, 8'h3C, 8'h0F, 12, 0);
        run_load(1'b0, 0);
        verify(5, 1'b0);

        // Randomised data and source stalls.
        for (int t = 0; t < 6; t++) begin
            set_src(8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)));
            run_load(1'b0, 0);
            verify(-1, 1'b0);
        end

`ifdef LOADER_READBACK_EN
        // Corrupt the chain between load exit and readback.
        set_src(8'hA5, 8'h3C, 8'h0F, 0, 0);
        flip_at  = nshift + N;
        flip_arm = 1'b1;
        run_load(1'b0, 0);
        flip_arm = 1'b0;
        verify(0, 1'b1);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(error), 32'd1);
        run_load(1'b0, 0);
        verify(0, 1'b0);
`endif

        // Reset in the middle of a load.
        set_src(8'h5A, 8'hC3, 8'hF0, 0, 0);
        run_load(1'b0, 9);
        @(negedge clk);
        check("mid_rst_outs",
              32'({in_ready, prog_en, prog_in, busy, done, error}), 32'd0);
        check("mid_rst_sig", 32'(signature), 32'd0);
        rst = 1'b1;
        set_src(8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
        run_load(1'b0, 0);
        verify(0, 1'b0);

        // start during LOAD and during the DONE cycle is ignored.
        set_src(8'h81, 8'h7E, 8'h99, 0, 0);
        run_load(1'b1, 0);
        verify(0, 1'b0);
        start = 1'b1;
        x_en = 0;
        x_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (prog_en) x_en++;
            if (done) x_done++;
        end
        check("ignored_start_en", x_en, 0);
        check("ignored_start_done", x_done, 0);
        check("ignored_start_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
